id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the 32-bit ALU.
- Latches decoded operands and control from ID, forwards results from EX/MEM and MEM/WB, and drives the ALU's A, B and 3-bit operation inputs.
- Passes the memory and writeback controls downstream.
- Flags load-use hazards to the hazard/stall logic.

Parameters:
- W, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  load a bubble
- in_valid  in  1  ID slot holds a real instruction
- in_pc  in  W  PC of the ID instruction
- in_rs_data, in_rt_data  in  W  register-file read data
- in_imm  in  W  sign-extended immediate; bits [10:6] carry shamt for shifts
- in_rs, in_rt, in_rd  in  RW  source and destination indices
- in_alu_op  in  3  ALU operation code (000 AND … 111 SLT)
- in_alu_src_b  in  1  1 selects immediate for B
- in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg  in  1  downstream controls
- exmem_reg_write  in  1;  exmem_rd  in  RW;  exmem_alu_res  in  W  EX/MEM forward source
- memwb_reg_write  in  1;  memwb_rd  in  RW;  memwb_data  in  W  MEM/WB forward source
- alu_A, alu_B  out  W  ALU operands
- alu_operation  out  3  ALU operation
- ex_store_data  out  W  forwarded rt value, for stores
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered controls
- ex_rd  out  RW;  ex_pc  out  W  registered destination index and PC
- load_use_hazard  out  1  combinational stall request

Behaviour:
- Register update on each clk edge, in priority order: rst > flush > stall > load.
- rst: every registered field is cleared. This means ex_valid=0, all controls=0, alu_operation=000, ex_rd=0, and ex_pc, data and imm registers=0.
- Combinational outputs after reset follow from the zeroed registers: alu_A=alu_B=0, load_use_hazard=0.
- flush: loads a bubble, with the same values as reset. flush and stall asserted together gives a bubble.
- stall without flush: every register holds its value and the outputs are unchanged.
- load with in_valid=0: data fields are captured, but valid and all control bits are forced to 0 and ex_rd to 0.
- Latency: ID inputs appear on the ALU ports one cycle after capture. Forwarding and the B mux are combinational from the registers and the forward sources, with no extra cycle.
- Forwarding selection, evaluated separately for the rs and rt operands:
  - Use exmem_alu_res if exmem_reg_write and exmem_rd!=0 and exmem_rd equals the operand index.
  - Otherwise use memwb_data under the same rule with the memwb signals.
  - Otherwise use the registered data.
  - EX/MEM always has priority over MEM/WB. Register 0 is never forwarded.
- Operand outputs:
  - alu_A = forwarded rs.
  - alu_B = in_alu_src_b(reg) ? imm(reg) : forwarded rt.
  - ex_store_data = forwarded rt, regardless of alu_src_b.
- Shifts: the decoder sets alu_src_b=1 so that B[10:6] carries shamt. This stage does not modify imm.
- load_use_hazard = ex_valid & ex_mem_read & ex_rd!=0 & (ex_rd==in_rs | ex_rd==in_rt). It is gated by in_valid. The external hazard unit responds by asserting stall on IF/ID and flush on this stage.
- Widths are full 32-bit with no truncation. Index compares are RW bits.

Optional Feature:
- Macro: EX_FORWARD_EN.
- Defined: forwarding behaves as described under Behaviour.
- Undefined:
  - alu_A and ex_store_data come from the registered rs/rt data only.
  - B selects between imm and registered rt.
  - The exmem_*/memwb_* inputs are ignored, with no logic generated.
  - load_use_hazard becomes a full RAW hazard: it also fires on a match against ex_rd when ex_reg_write (not only mem_read), so that software-invisible stalls replace forwarding.

Test Plan:
- Reset: hold rst for 2 cycles while in_valid=1 and in_alu_op=010 → ex_valid=0, alu_operation=000, all controls 0, alu_A=alu_B=0.
- Plain capture: rs_data=0x5, imm=0x10, alu_src_b=1, op=010, valid=1 → next cycle alu_A=0x5, alu_B=0x10, alu_operation=010, ex_valid=1.
- Forward priority: registered rs=3 with rs_data=0x1, exmem_rd=3 with res=0xAA, memwb_rd=3 with data=0xBB, both reg_write=1 → alu_A=0xAA. Dropping exmem_reg_write → 0xBB. Setting rs=0 with all matches → registered value.
- Stall/flush: with captured op=110, stall=1 for 3 cycles while inputs change → outputs unchanged. Then stall=1 and flush=1 → ex_valid=0, reg_write=0, alu_operation=000.
- Load-use: ex_mem_read=1, ex_rd=8, ex_valid=1, in_rt=8, in_valid=1 → load_use_hazard=1. With in_valid=0 or ex_rd=0 → 0.
- Shift/store path: alu_src_b=1, imm=0x0000_0080 (shamt 2), rt forwarded from memwb=0x1234 → alu_B=0x80 and ex_store_data=0x1234.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and ALU operand-select stage with EX/MEM and MEM/WB forwarding.
// Define EX_FORWARD_EN to build the forwarding muxes; otherwise load_use_hazard covers all RAW hazards.
module id_ex_operand_stage #(
  parameter int W  = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [W-1:0]  in_pc,
  input  logic [W-1:0]  in_rs_data,
  input  logic [W-1:0]  in_rt_data,
  input  logic [W-1:0]  in_imm,
  input  logic [RW-1:0] in_rs,
  input  logic [RW-1:0] in_rt,
  input  logic [RW-1:0] in_rd,
  input  logic [2:0]    in_alu_op,
  input  logic          in_alu_src_b,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          in_mem_to_reg,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [W-1:0]  exmem_alu_res,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [W-1:0]  memwb_data,
  output logic [W-1:0]  alu_A,
  output logic [W-1:0]  alu_B,
  output logic [2:0]    alu_operation,
  output logic [W-1:0]  ex_store_data,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic [RW-1:0] ex_rd,
  output logic [W-1:0]  ex_pc,
  output logic          load_use_hazard
);

  typedef struct packed {
    logic          valid;
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic [RW-1:0] rd;
    logic [W-1:0]  pc;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic [W-1:0]  imm;
    logic [2:0]    alu_op;
    logic          alu_src_b;
  } stage_t;

  stage_t        stage_q, stage_d;
  logic [W-1:0]  fwd_rs, fwd_rt;
  logic          hazard_src;

  // Invalid slots still capture data, but must never look like a producer downstream.
  always_comb begin
    stage_d = stage_q;
    if (flush) begin
      stage_d = '0;
    end else if (!stall) begin
      stage_d.valid      = in_valid;
      stage_d.reg_write  = in_valid & in_reg_write;
      stage_d.mem_read   = in_valid & in_mem_read;
      stage_d.mem_write  = in_valid & in_mem_write;
      stage_d.mem_to_reg = in_valid & in_mem_to_reg;
      stage_d.rd         = in_valid ? in_rd : '0;
      stage_d.pc         = in_pc;
      stage_d.rs_data    = in_rs_data;
      stage_d.rt_data    = in_rt_data;
      stage_d.imm        = in_imm;
      stage_d.alu_op     = in_alu_op;
      stage_d.alu_src_b  = in_alu_src_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stage_q <= '0;
    else     stage_q <= stage_d;
  end

`ifdef EX_FORWARD_EN
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d;

  always_comb begin
    rs_d = rs_q;
    rt_d = rt_q;
    if (flush) begin
      rs_d = '0;
      rt_d = '0;
    end else if (!stall) begin
      rs_d = in_rs;
      rt_d = in_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs_q <= '0;
      rt_q <= '0;
    end else begin
      rs_q <= rs_d;
      rt_q <= rt_d;
    end
  end

  // EX/MEM is the younger producer, so it wins over MEM/WB; r0 is never forwarded.
  always_comb begin
    fwd_rs = stage_q.rs_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q))
      fwd_rs = exmem_alu_res;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q))
      fwd_rs = memwb_data;
  end

  always_comb begin
    fwd_rt = stage_q.rt_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q))
      fwd_rt = exmem_alu_res;
    else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q))
      fwd_rt = memwb_data;
  end

  assign hazard_src = stage_q.mem_read;
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_alu_res,
                        memwb_reg_write, memwb_rd, memwb_data};
  assign fwd_rs     = stage_q.rs_data;
  assign fwd_rt     = stage_q.rt_data;
  // Without forwarding every in-flight register write must stall the consumer.
  assign hazard_src = stage_q.mem_read | stage_q.reg_write;
`endif

  assign alu_A         = fwd_rs;
  assign alu_B         = stage_q.alu_src_b ? stage_q.imm : fwd_rt;
  assign alu_operation = stage_q.alu_op;
  assign ex_store_data = fwd_rt;
  assign ex_valid      = stage_q.valid;
  assign ex_reg_write  = stage_q.reg_write;
  assign ex_mem_read   = stage_q.mem_read;
  assign ex_mem_write  = stage_q.mem_write;
  assign ex_mem_to_reg = stage_q.mem_to_reg;
  assign ex_rd         = stage_q.rd;
  assign ex_pc         = stage_q.pc;

  assign load_use_hazard = in_valid & stage_q.valid & hazard_src & (stage_q.rd != '0) &
                           ((stage_q.rd == in_rs) | (stage_q.rd == in_rt));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Randomized + directed bench for id_ex_operand_stage against a behavioural model of the stage.
// Honours EX_FORWARD_EN the same way the design does.
module tb_id_ex_operand_stage;
  localparam int W  = 32;
  localparam int RW = 5;
`ifdef EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, stall, flush, in_valid;
  logic [W-1:0] in_pc, in_rs_data, in_rt_data, in_imm;
  logic [RW-1:0] in_rs, in_rt, in_rd;
  logic [2:0] in_alu_op;
  logic in_alu_src_b, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
  logic exmem_reg_write, memwb_reg_write;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [W-1:0] exmem_alu_res, memwb_data;
  logic [W-1:0] alu_A, alu_B, ex_store_data, ex_pc;
  logic [2:0] alu_operation;
  logic ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, load_use_hazard;
  logic [RW-1:0] ex_rd;

  id_ex_operand_stage #(.W(W), .RW(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data), .in_imm(in_imm),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_alu_op(in_alu_op),
    .in_alu_src_b(in_alu_src_b), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_alu_res(exmem_alu_res),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_operation(alu_operation), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd), .ex_pc(ex_pc),
    .load_use_hazard(load_use_hazard)
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model of the instruction currently held in EX
  bit          m_valid, m_rw, m_mr, m_mw, m_m2r, m_srcb, m_opb_known;
  bit [RW-1:0] m_rd, m_rs, m_rt;
  bit [W-1:0]  m_pc, m_rsd, m_rtd, m_imm;
  bit [2:0]    m_op;

  function automatic logic [W-1:0] operand(input bit [RW-1:0] idx, input bit [W-1:0] regv);
    if (FWD && exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_alu_res;
    if (FWD && memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_data;
    return regv;
  endfunction

  task automatic model_clock();
    if (rst || flush) begin
      {m_valid, m_rw, m_mr, m_mw, m_m2r, m_srcb} = '0;
      m_rd = 0; m_rs = 0; m_rt = 0; m_pc = 0; m_rsd = 0; m_rtd = 0; m_imm = 0; m_op = 0;
      m_opb_known = 1;
    end else if (!stall) begin
      m_valid = in_valid;
      m_rw  = in_valid && in_reg_write;
      m_mr  = in_valid && in_mem_read;
      m_mw  = in_valid && in_mem_write;
      m_m2r = in_valid && in_mem_to_reg;
      m_rd  = in_valid ? in_rd : 0;
      m_pc = in_pc; m_rsd = in_rs_data; m_rtd = in_rt_data; m_imm = in_imm;
      m_rs = in_rs; m_rt = in_rt; m_op = in_alu_op; m_srcb = in_alu_src_b;
      // op/B-select of a non-instruction are don't-care downstream
      m_opb_known = in_valid;
    end
  endtask

  task automatic check_model();
    logic [W-1:0] ea, est;
    bit producer, hz;
    #1;
    ea  = operand(m_rs, m_rsd);
    est = operand(m_rt, m_rtd);
    producer = FWD ? m_mr : (m_mr || m_rw);
    hz = in_valid && m_valid && producer && m_rd != 0 && (m_rd == in_rs || m_rd == in_rt);
    check_eq("alu_A", alu_A, ea);
    check_eq("store_data", ex_store_data, est);
    if (m_opb_known) begin
      check_eq("alu_B", alu_B, m_srcb ? m_imm : est);
      check_eq("alu_op", 32'(alu_operation), 32'(m_op));
    end
    check_eq("ex_valid", 32'(ex_valid), 32'(m_valid));
    check_eq("ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}),
             32'({m_rw, m_mr, m_mw, m_m2r}));
    check_eq("ex_rd", 32'(ex_rd), 32'(m_rd));
    check_eq("ex_pc", ex_pc, m_pc);
    check_eq("hazard", 32'(load_use_hazard), 32'(hz));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    @(negedge clk);
    check_model();
  endtask

  task automatic rand_inputs(input bit allow_rst);
    rst        = allow_rst && ($urandom_range(0, 49) == 0);
    flush      = ($urandom_range(0, 9) == 0);
    stall      = ($urandom_range(0, 4) == 0);
    in_valid   = ($urandom_range(0, 4) != 0);
    in_pc      = $urandom; in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
    in_rs      = RW'($urandom_range(0, 3)); in_rt = RW'($urandom_range(0, 3));
    in_rd      = RW'($urandom_range(0, 3));
    in_alu_op  = 3'($urandom); in_alu_src_b = 1'($urandom);
    {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = 4'($urandom);
    exmem_reg_write = 1'($urandom); exmem_rd = RW'($urandom_range(0, 3)); exmem_alu_res = $urandom;
    memwb_reg_write = 1'($urandom); memwb_rd = RW'($urandom_range(0, 3)); memwb_data = $urandom;
  endtask

  task automatic quiet_inputs();
    stall = 0; flush = 0; rst = 0; in_valid = 1;
    {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg} = '0;
    exmem_reg_write = 0; memwb_reg_write = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_alu_res = 0; memwb_data = 0; in_rs = 1; in_rt = 2; in_rd = 0;
  endtask

  initial begin
    rand_inputs(1'b0);
    // Reset held two cycles over a live instruction
    rst = 1; in_valid = 1; in_alu_op = 3'b010; flush = 0; stall = 0;
    step(); step();
    check_eq("rst_valid", 32'(ex_valid), 0);
    check_eq("rst_op", 32'(alu_operation), 0);
    check_eq("rst_A", alu_A, 0);
    check_eq("rst_B", alu_B, 0);

    // Plain capture
    quiet_inputs();
    in_rs_data = 32'h5; in_imm = 32'h10; in_alu_src_b = 1; in_alu_op = 3'b010;
    step();
    check_eq("cap_A", alu_A, 32'h5);
    check_eq("cap_B", alu_B, 32'h10);
    check_eq("cap_op", 32'(alu_operation), 32'h2);
    check_eq("cap_valid", 32'(ex_valid), 1);

    // Forward priority on rs
    in_rs = 3; in_rs_data = 32'h1;
    step();
    exmem_reg_write = 1; exmem_rd = 3; exmem_alu_res = 32'hAA;
    memwb_reg_write = 1; memwb_rd = 3; memwb_data = 32'hBB;
    check_model();
    check_eq("fwd_exmem", alu_A, FWD ? 32'hAA : 32'h1);
    exmem_reg_write = 0;
    check_model();
    check_eq("fwd_memwb", alu_A, FWD ? 32'hBB : 32'h1);
    exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0; in_rs = 0;
    step();
    check_eq("fwd_r0", alu_A, 32'h1);

    // Stall holds, stall+flush gives a bubble
    quiet_inputs();
    in_alu_op = 3'b110; in_reg_write = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(1'b0);
      stall = 1; flush = 0;
      step();
      check_eq("stall_op", 32'(alu_operation), 32'h6);
    end
    stall = 1; flush = 1;
    step();
    check_eq("flush_valid", 32'(ex_valid), 0);
    check_eq("flush_rw", 32'(ex_reg_write), 0);
    check_eq("flush_op", 32'(alu_operation), 0);

    // Load-use detection
    quiet_inputs();
    in_mem_read = 1; in_rd = 8;
    step();
    in_mem_read = 0; in_rt = 8; in_rs = 1;
    check_model();
    check_eq("lu_hit", 32'(load_use_hazard), 1);
    in_valid = 0;
    check_model();
    check_eq("lu_invalid", 32'(load_use_hazard), 0);
    in_valid = 1; in_mem_read = 1; in_rd = 0;
    step();
    in_rt = 0;
    check_model();
    check_eq("lu_rd0", 32'(load_use_hazard), 0);

    // Shift/store path: imm to B, forwarded rt to store data
    quiet_inputs();
    in_alu_src_b = 1; in_imm = 32'h0000_0080; in_rt = 4; in_rt_data = 32'h55;
    step();
    memwb_reg_write = 1; memwb_rd = 4; memwb_data = 32'h1234;
    check_model();
    check_eq("shamt_B", alu_B, 32'h80);
    check_eq("store_fwd", ex_store_data, FWD ? 32'h1234 : 32'h55);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rand_inputs(1'b1);
      check_model();
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
